icache_assoc: RTL and testbench

//  Parametrised N-way set-associative instruction cache between the fetch stage and instruction memory.

---
 rtl/icache_assoc.sv | 127 ++++++++++++
 tb/tb_icache_assoc.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/icache_assoc.sv
// icache_assoc: N-way set-associative instruction cache with round-robin replacement and flush.
//   clk, rst      clock, synchronous active-high reset
//   PC, Flush     fetch byte address, invalidate-all pulse
//   Instr         fetched instruction (NOP_INSTR while stalled)
//   CacheStall    freeze fetch on miss, fill wait or flush
//   MemRead       line request, held until MemReady
//   PCMem         line-aligned address of the requested line
//   MemLine       returned line, word 0 in the low bits
//   MemReady      one-cycle pulse qualifying MemLine
module icache_assoc #(
    parameter int WORD_SIZE      = 32,
    parameter int NUM_SETS       = 4,
    parameter int NUM_WAYS       = 2,
    parameter int WORDS_PER_LINE = 4,
    parameter logic [WORD_SIZE-1:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [WORD_SIZE-1:0]                PC,
    input  logic                                Flush,
    output logic [WORD_SIZE-1:0]                Instr,
    output logic                                CacheStall,
    output logic                                MemRead,
    output logic [WORD_SIZE-1:0]                PCMem,
    input  logic [WORD_SIZE*WORDS_PER_LINE-1:0] MemLine,
    input  logic                                MemReady
);
    localparam int OFF_W  = $clog2(WORDS_PER_LINE);
    localparam int IDX_W  = $clog2(NUM_SETS);
    localparam int WAY_W  = NUM_WAYS > 1 ? $clog2(NUM_WAYS) : 1;
    localparam int TAG_LO = OFF_W + IDX_W + 2;
    localparam int TAG_W  = WORD_SIZE - TAG_LO;
    localparam int LINE_W = WORD_SIZE * WORDS_PER_LINE;

    typedef enum logic [1:0] {IDLE, MISS, FLUSH} state_t;

    state_t               state_q;
    logic [NUM_WAYS-1:0]  valid_q [NUM_SETS];
    logic [TAG_W-1:0]     tag_q   [NUM_SETS][NUM_WAYS];
    logic [LINE_W-1:0]    data_q  [NUM_SETS][NUM_WAYS];
    logic [WAY_W-1:0]     rr_q    [NUM_SETS];
    logic [WORD_SIZE-1:0] pcmem_q;
    logic                 memread_q;
    logic                 flush_pend_q;

    logic [IDX_W-1:0] idx, m_idx;
    logic [OFF_W-1:0] off;
    logic [TAG_W-1:0] tag, m_tag;
    logic             hit;
    logic [WAY_W-1:0] hit_way, victim, rr_d;
    logic             unused_pc;

    assign idx       = PC[OFF_W+2 +: IDX_W];
    assign off       = PC[2 +: OFF_W];
    assign tag       = PC[WORD_SIZE-1:TAG_LO];
    assign m_idx     = pcmem_q[OFF_W+2 +: IDX_W];
    assign m_tag     = pcmem_q[WORD_SIZE-1:TAG_LO];
    assign unused_pc = ^PC[1:0];

    // Descending scan so the lowest matching way wins.
    always_comb begin
        hit     = 1'b0;
        hit_way = '0;
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (valid_q[idx][w] && tag_q[idx][w] == tag) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
    end

    // Lowest invalid way first, otherwise the set's round-robin pointer.
    always_comb begin
        victim = NUM_WAYS == 1 ? '0 : rr_q[m_idx];
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (!valid_q[m_idx][w]) victim = WAY_W'(w);
        end
    end

    assign rr_d       = NUM_WAYS == 1 ? '0 : WAY_W'(rr_q[m_idx] + 1'b1);
    assign Instr      = (!rst && state_q == IDLE && hit) ? data_q[idx][hit_way][int'(off)*WORD_SIZE +: WORD_SIZE] : NOP_INSTR;
    assign CacheStall = !rst && (state_q != IDLE || !hit);
    assign MemRead    = memread_q;
    assign PCMem      = pcmem_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            pcmem_q      <= '0;
            memread_q    <= 1'b0;
            flush_pend_q <= 1'b0;
            for (int s = 0; s < NUM_SETS; s++) begin
                valid_q[s] <= '0;
                rr_q[s]    <= '0;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    if (Flush) begin
                        state_q <= FLUSH;
                    end else if (!hit) begin
                        pcmem_q   <= {PC[WORD_SIZE-1:OFF_W+2], {(OFF_W+2){1'b0}}};
                        memread_q <= 1'b1;
                        state_q   <= MISS;
                    end
                end
                MISS: begin
                    if (MemReady) begin
                        data_q[m_idx][victim]  <= MemLine;
                        tag_q[m_idx][victim]   <= m_tag;
                        valid_q[m_idx][victim] <= 1'b1;
                        rr_q[m_idx]            <= rr_d;
                        memread_q              <= 1'b0;
                        flush_pend_q           <= 1'b0;
                        state_q                <= (flush_pend_q || Flush) ? FLUSH : IDLE;
                    end else if (Flush) begin
                        flush_pend_q <= 1'b1;
                    end
                end
                default: begin
                    for (int s = 0; s < NUM_SETS; s++) valid_q[s] <= '0;
                    state_q <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_icache_assoc.sv
// tb_icache_assoc: directed scoreboard bench for icache_assoc.
module tb_icache_assoc;
    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         Flush = 1'b0;
    logic         MemReady = 1'b0;
    logic [31:0]  PC = '0;
    logic [127:0] MemLine = '0;
    logic [31:0]  Instr, PCMem;
    logic         CacheStall, MemRead;

    localparam logic [31:0] NOP = 32'h0000_0013;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_instr_q[$];
    logic [31:0] exp_req_q[$];
    logic fetch_en = 1'b0;
    logic auto_mem = 1'b0;
    int pulse_req = 0;
    int pulse_done = 0;

    icache_assoc dut (
        .clk(clk), .rst(rst), .PC(PC), .Flush(Flush), .Instr(Instr),
        .CacheStall(CacheStall), .MemRead(MemRead), .PCMem(PCMem),
        .MemLine(MemLine), .MemReady(MemReady)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] line_of(input logic [31:0] a);
        logic [127:0] l;
        for (int i = 0; i < 4; i++) l[i*32 +: 32] = 32'h1000_0000 | (a + 32'(4 * i));
        return l;
    endfunction

    // Instruction monitor: pops the expected word whenever a fetch is delivered.
    always @(negedge clk) begin
        if (fetch_en && !rst && !CacheStall) begin
            if (exp_instr_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_instr: got %h expected none", Instr);
            end else begin
                chk("instr", Instr, exp_instr_q.pop_front());
            end
        end
    end

    // Memory model: checks each new request, answers 3 cycles after MemRead rises.
    initial begin
        int cnt = 0;
        forever begin
            @(negedge clk);
            MemReady = 1'b0;
            if (MemRead) begin
                cnt++;
                if (cnt == 1) begin
                    if (exp_req_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_memread: got %h expected none", PCMem);
                    end else begin
                        chk("pcmem", PCMem, exp_req_q.pop_front());
                    end
                end
                if (auto_mem && cnt == 3) begin
                    MemReady = 1'b1;
                    MemLine  = line_of(PCMem);
                end
            end else begin
                cnt = 0;
            end
            if (pulse_req != pulse_done) begin
                pulse_done++;
                MemReady = 1'b1;
                MemLine  = {4{32'hBAD0_BAD0}};
            end
        end
    end

    task automatic fetch(input logic [31:0] pc, input logic [31:0] exp, input bit miss);
        int n = 0;
        if (miss) exp_req_q.push_back({pc[31:4], 4'h0});
        exp_instr_q.push_back(exp);
        PC = pc;
        fetch_en = 1'b1;
        forever begin
            @(negedge clk);
            if (n == 0) chk("stall_at_lookup", {31'b0, CacheStall}, {31'b0, miss});
            if (n == 1 && miss) chk("memread_rise", {31'b0, MemRead}, 32'd1);
            if (!CacheStall) begin
                chk("latency", n, miss ? 32'd4 : 32'd0);
                break;
            end
            n++;
            if (n > 30) begin
                checks++;
                errors++;
                $display("FAIL fill_timeout: got stall after %0d cycles expected delivery", n);
                break;
            end
        end
        @(posedge clk); #1;
        fetch_en = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        @(negedge clk);
        @(negedge clk);
        chk("rst_stall", {31'b0, CacheStall}, 32'd0);
        chk("rst_instr", Instr, NOP);
        chk("rst_memread", {31'b0, MemRead}, 32'd0);
        chk("rst_pcmem", PCMem, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        auto_mem = 1'b1;
        // cold miss then hits on the rest of the line
        fetch(32'h000, 32'h1000_0000, 1);
        fetch(32'h004, 32'h1000_0004, 0);
        fetch(32'h008, 32'h1000_0008, 0);
        fetch(32'h00C, 32'h1000_000C, 0);
        // conflicts in set 0
        fetch(32'h040, 32'h1000_0040, 1);
        fetch(32'h080, 32'h1000_0080, 1);
        fetch(32'h040, 32'h1000_0040, 0);
        fetch(32'h000, 32'h1000_0000, 1);
        fetch(32'h044, 32'h1000_0044, 1);
        fetch(32'h008, 32'h1000_0008, 0);
        // unaligned miss
        fetch(32'h018, 32'h1000_0018, 1);
        fetch(32'h010, 32'h1000_0010, 0);
        fetch(32'h01C, 32'h1000_001C, 0);
        // flush in IDLE
        Flush = 1'b1;
        @(negedge clk);
        chk("flush_req_nostall", {31'b0, CacheStall}, 32'd0);
        @(posedge clk); #1;
        Flush = 1'b0;
        PC = 32'h000;
        @(negedge clk);
        chk("flush_stall", {31'b0, CacheStall}, 32'd1);
        chk("flush_nop", Instr, NOP);
        chk("flush_memread", {31'b0, MemRead}, 32'd0);
        @(posedge clk); #1;
        fetch(32'h000, 32'h1000_0000, 1);
        fetch(32'h01C, 32'h1000_001C, 1);
        // flush during MISS
        exp_req_q.push_back(32'h020);
        PC = 32'h020;
        @(negedge clk);
        chk("miss20_stall", {31'b0, CacheStall}, 32'd1);
        @(posedge clk); #1;
        Flush = 1'b1;
        @(negedge clk);
        chk("miss20_memread", {31'b0, MemRead}, 32'd1);
        @(posedge clk); #1;
        Flush = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("pend_flush_stall", {31'b0, CacheStall}, 32'd1);
        chk("pend_flush_memread", {31'b0, MemRead}, 32'd0);
        @(posedge clk); #1;
        fetch(32'h024, 32'h1000_0024, 1);
        fetch(32'h020, 32'h1000_0020, 0);
        // reset mid-MISS, then a stray MemReady
        auto_mem = 1'b0;
        exp_req_q.push_back(32'h030);
        PC = 32'h030;
        @(negedge clk);
        chk("miss30_stall", {31'b0, CacheStall}, 32'd1);
        @(negedge clk);
        chk("miss30_memread", {31'b0, MemRead}, 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        PC = 32'h000;
        @(negedge clk);
        @(negedge clk);
        chk("midrst_memread", {31'b0, MemRead}, 32'd0);
        chk("midrst_stall", {31'b0, CacheStall}, 32'd0);
        chk("midrst_pcmem", PCMem, 32'h0);
        chk("midrst_instr", Instr, NOP);
        @(posedge clk); #1;
        rst = 1'b0;
        pulse_req++;
        auto_mem = 1'b1;
        fetch(32'h000, 32'h1000_0000, 1);
        fetch(32'h030, 32'h1000_0030, 1);
        @(posedge clk); #1;
        chk("instr_queue_empty", exp_instr_q.size(), 32'd0);
        chk("req_queue_empty", exp_req_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
